fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- PC register, instruction-memory request/response master and IF/ID pipeline register.
- Consumes the stall controls from the load-use hazard logic (PCWrite, IF_ID_Write) and the branch redirect/flush from EX.
- Presents PC_ID/Instr_ID/Valid_ID to the decode stage.
- Allows one outstanding imem request, with a 1-entry fetch buffer so responses arriving during a stall are never lost.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
PCWrite  in  1  1 = PC may advance/issue; 0 = freeze PC, no new request
IF_ID_Write  in  1  1 = IF/ID may load; 0 = hold IF/ID
Flush_ID  in  1  branch/jump taken in EX: redirect and squash
BranchTarget  in  XLEN  redirect address, valid when Flush_ID=1
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request address (= pc_f)
imem_rsp_valid  in  1  response valid (one pulse per accepted request, latency >=1)
imem_rsp_data  in  32  instruction word
PC_ID  out  XLEN  PC of instruction in IF/ID
Instr_ID  out  32  instruction in IF/ID
Valid_ID  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (sync, active-high):
  - pc_f=RESET_PC; state=IDLE; buffer empty.
  - PC_ID=0, Instr_ID=NOP_INSTR, Valid_ID=0, imem_req_valid=0.
  - Reset mid-transaction abandons the outstanding response: state returns to IDLE with no drop pending, and the memory must also be reset.
- State machine:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its PC is held in pc_inflight.
  - WAIT_DROP: one request outstanding; its response is to be discarded.
- Request issue:
  - imem_req_valid = PCWrite & ~Flush_ID & buf_empty & (state==IDLE | (state==WAIT & imem_rsp_valid & IF_ID_Write)).
  - The last term gives back-to-back fetch: 1 instr/cycle at 1-cycle memory latency.
  - imem_req_valid is combinational on its inputs.
  - Handshake (valid&ready): pc_inflight<=pc_f; pc_f<=pc_f+4 (mod 2^XLEN, wraps); state<=WAIT.
  - If a request is not accepted, pc_f holds. The request may be withdrawn if its conditions drop (memory tolerates this).
- Response in WAIT (imem_rsp_valid):
  - If IF_ID_Write=1 and buffer empty: IF/ID <= {pc_inflight, data, 1}.
  - Else: buffer <= {pc_inflight, data}.
  - State goes to IDLE, unless a new handshake happens in the same cycle (then WAIT).
- Response in WAIT_DROP: discarded; state goes to IDLE. No request issues in that cycle.
- IF/ID update when IF_ID_Write=1 and no flush, in priority order:
  - buffer entry (buffer then empties);
  - else the live non-dropped response;
  - else bubble: Valid_ID=0, Instr_ID=NOP_INSTR, PC_ID holds.
- IF_ID_Write=0: IF/ID holds all three outputs.
- Flush_ID=1 (highest priority, overrides IF_ID_Write, PCWrite, reset excepted):
  - pc_f <= {BranchTarget[XLEN-1:2],2'b00}.
  - IF/ID <= bubble; buffer cleared.
  - WAIT -> WAIT_DROP. A response arriving in the flush cycle is discarded and the state goes to IDLE.
  - No request issues in the flush cycle. The first fetch from the target occurs in the next cycle at the earliest.
- Flush in WAIT_DROP: retarget pc_f only; state stays WAIT_DROP.
- PCWrite=0 with IF_ID_Write=1 is legal: IF/ID drains the buffer or fills with bubbles.
- Invariants:
  - At most 1 request outstanding.
  - Buffer is never written while full, because issue requires buf_empty.
  - No instruction is duplicated or lost absent a flush.

Decomposition:
- Shared pipeline package holds:
  - XLEN and NOP_INSTR constants;
  - the fetch state enum {IDLE, WAIT, WAIT_DROP};
  - an if_id_t struct {pc, instr, valid}, reused by decode.
- One natural sub-module: fetch_buffer, a 1-entry skid register with wr/rd/clear and a full flag.

Test Plan:
1. Reset, then 1-cycle-latency memory always ready, no stalls -> requests at 0,4,8,C on consecutive cycles; Valid_ID=1 from cycle 3, PC_ID advancing by 4 each cycle.
2. IF_ID_Write=0, PCWrite=0 for 2 cycles while a response for PC 0x8 arrives -> it goes to the buffer; IF/ID holds PC 0x4; no request issues. On release, IF/ID=0x8 next cycle, then 0xC fetched; no loss or duplicate.
3. Flush_ID=1, BranchTarget=0x103 while a request for 0x10 is outstanding with latency 3 -> 0x10 response discarded; IF/ID bubble (Instr_ID=0x13, Valid_ID=0); next request addr=0x100.
4. Flush in the same cycle as imem_rsp_valid, with the buffer full -> both the buffer entry and the response are discarded; pc_f=target; the first instruction after the flush comes from the target.
5. imem_req_ready=0 for 4 cycles -> pc_f and imem_req_addr stable; Valid_ID goes to bubbles; on ready the handshake happens once and pc_f advances by exactly 4.
6. pc_f=0xFFFF_FFFC, fetch -> next address 0x0000_0000 (wrap). Reset asserted mid-WAIT -> next cycle all outputs at reset values and state=IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared pipeline types and constants for the fetch stage and its consumers.
package fetch_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_buffer.sv
// One-entry skid register holding a fetched {pc, instr} while IF/ID is stalled.
module fetch_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic            rd,
  input  logic            clr,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [31:0]     wr_instr,
  output logic            full,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_instr
);
  logic            full_q, full_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (wr) begin
      full_d  = 1'b1;
      pc_d    = wr_pc;
      instr_d = wr_instr;
    end else if (rd) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full     = full_q;
  assign rd_pc    = pc_q;
  assign rd_instr = instr_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem master, skid buffer and IF/ID register.
module fetch_stage #(
  parameter int                XLEN      = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            IF_ID_Write,
  input  logic            Flush_ID,
  input  logic [XLEN-1:0] BranchTarget,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] PC_ID,
  output logic [31:0]     Instr_ID,
  output logic            Valid_ID
);
  import fetch_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            id_valid_q, id_valid_d;

  logic            buf_wr, buf_rd, buf_clr, buf_full;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_instr;
  logic            rsp_live, hs;

  fetch_buffer #(.XLEN(XLEN)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr       (buf_wr),
    .rd       (buf_rd),
    .clr      (buf_clr),
    .wr_pc    (pc_inflight_q),
    .wr_instr (imem_rsp_data),
    .full     (buf_full),
    .rd_pc    (buf_pc),
    .rd_instr (buf_instr)
  );

  assign rsp_live = imem_rsp_valid && (state_q == WAIT);

  // Issuing in WAIT is only allowed when the current response retires this cycle.
  assign imem_req_valid = !reset && PCWrite && !Flush_ID && !buf_full &&
                          ((state_q == IDLE) || (rsp_live && IF_ID_Write));
  assign hs             = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc_f_q;

  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    pc_inflight_d = pc_inflight_q;
    id_pc_d       = id_pc_q;
    id_instr_d    = id_instr_q;
    id_valid_d    = id_valid_q;
    buf_wr        = 1'b0;
    buf_rd        = 1'b0;
    buf_clr       = 1'b0;

    if (Flush_ID) begin
      pc_f_d     = BranchTarget & ~XLEN'(3);
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      buf_clr    = 1'b1;
      unique case (state_q)
        WAIT, WAIT_DROP: state_d = imem_rsp_valid ? IDLE : WAIT_DROP;
        default:         state_d = IDLE;
      endcase
    end else begin
      if (hs) begin
        pc_inflight_d = pc_f_q;
        pc_f_d        = pc_f_q + XLEN'(4);
        state_d       = WAIT;
      end else if (imem_rsp_valid && state_q != IDLE) begin
        state_d = IDLE;
      end

      // Live response skids into the buffer unless it can go straight to IF/ID.
      if (rsp_live && !(IF_ID_Write && !buf_full)) buf_wr = 1'b1;

      if (IF_ID_Write) begin
        if (buf_full) begin
          id_pc_d    = buf_pc;
          id_instr_d = buf_instr;
          id_valid_d = 1'b1;
          buf_rd     = 1'b1;
        end else if (rsp_live) begin
          id_pc_d    = pc_inflight_q;
          id_instr_d = imem_rsp_data;
          id_valid_d = 1'b1;
        end else begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_f_q        <= RESET_PC;
      pc_inflight_q <= '0;
      id_pc_q       <= '0;
      id_instr_q    <= NOP_INSTR;
      id_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      pc_inflight_q <= pc_inflight_d;
      id_pc_q       <= id_pc_d;
      id_instr_q    <= id_instr_d;
      id_valid_q    <= id_valid_d;
    end
  end

  assign PC_ID    = id_pc_q;
  assign Instr_ID = id_instr_q;
  assign Valid_ID = id_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle-table bench for fetch_stage with a hand-driven instruction memory.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, PCWrite, IF_ID_Write, Flush_ID;
  logic [31:0] BranchTarget;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] PC_ID, Instr_ID;
  logic        Valid_ID;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .Flush_ID(Flush_ID), .BranchTarget(BranchTarget),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .PC_ID(PC_ID), .Instr_ID(Instr_ID),
    .Valid_ID(Valid_ID)
  );

  typedef struct {
    logic        chk;
    logic        rst, pw, iw, fl;
    logic [31:0] bt;
    logic        rdy, rv;
    logic [31:0] rd;
    logic        qv;
    logic [31:0] qa, pc, in;
    logic        va;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic chk, input logic rst, input logic pw, input logic iw,
                   input logic fl, input logic [31:0] bt, input logic rdy, input logic rv,
                   input logic [31:0] rd, input logic qv, input logic [31:0] qa,
                   input logic [31:0] pc, input logic [31:0] in, input logic va);
    vec_t e;
    e.chk = chk; e.rst = rst; e.pw = pw; e.iw = iw; e.fl = fl; e.bt = bt;
    e.rdy = rdy; e.rv = rv; e.rd = rd; e.qv = qv; e.qa = qa; e.pc = pc;
    e.in = in; e.va = va;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h expected=%h", name, row, got, exp);
    end
  endtask

  task automatic check_outs(input int row, input logic qv, input logic [31:0] qa,
                            input logic [31:0] pc, input logic [31:0] in, input logic va);
    check("req_valid", row, {31'd0, imem_req_valid}, {31'd0, qv});
    check("req_addr",  row, imem_req_addr, qa);
    check("PC_ID",     row, PC_ID, pc);
    check("Instr_ID",  row, Instr_ID, in);
    check("Valid_ID",  row, {31'd0, Valid_ID}, {31'd0, va});
  endtask

  initial begin
    //  chk rst pw iw fl bt            rdy rv rd              qv qa            pc            in            va
    // reset
    v(0, 1, 1, 1, 0, 32'h0,        1, 0, 32'h0,          0, 32'h0,        32'h0,        32'h13,       0);
    v(1, 1, 1, 1, 0, 32'h0,        1, 0, 32'h0,          0, 32'h0,        32'h0,        32'h13,       0);
    // back-to-back fetch at 1-cycle latency
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          1, 32'h0,        32'h0,        32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 1, 32'hA000_0000,  1, 32'h4,        32'h0,        32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 1, 32'hA000_0004,  1, 32'h8,        32'h0,        32'hA000_0000, 1);
    // stall while the 0x8 response lands -> skid buffer
    v(1, 0, 0, 0, 0, 32'h0,        1, 1, 32'hA000_0008,  0, 32'hC,        32'h4,        32'hA000_0004, 1);
    v(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0,          0, 32'hC,        32'h4,        32'hA000_0004, 1);
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          0, 32'hC,        32'h4,        32'hA000_0004, 1);
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          1, 32'hC,        32'h8,        32'hA000_0008, 1);
    v(1, 0, 1, 1, 0, 32'h0,        1, 1, 32'hA000_000C,  1, 32'h10,       32'h8,        32'h13,       0);
    // flush to 0x103 while 0x10 outstanding with latency 3
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          0, 32'h14,       32'hC,        32'hA000_000C, 1);
    v(1, 0, 1, 1, 1, 32'h103,      1, 0, 32'h0,          0, 32'h14,       32'hC,        32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 1, 32'hA000_0010,  0, 32'h100,      32'hC,        32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          1, 32'h100,      32'hC,        32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 1, 32'hA000_0100,  1, 32'h104,      32'hC,        32'h13,       0);
    // fill buffer, then flush with the buffer full
    v(1, 0, 0, 0, 0, 32'h0,        1, 1, 32'hA000_0104,  0, 32'h108,      32'h100,      32'hA000_0100, 1);
    v(1, 0, 1, 0, 1, 32'h200,      1, 0, 32'h0,          0, 32'h108,      32'h100,      32'hA000_0100, 1);
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          1, 32'h200,      32'h100,      32'h13,       0);
    // flush in the same cycle as a live response
    v(1, 0, 1, 1, 1, 32'h300,      1, 1, 32'hA000_0200,  0, 32'h204,      32'h100,      32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          1, 32'h300,      32'h100,      32'h13,       0);
    // ready low for 4 cycles
    v(1, 0, 1, 1, 0, 32'h0,        0, 1, 32'hA000_0300,  1, 32'h304,      32'h100,      32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h304,      32'h300,      32'hA000_0300, 1);
    v(1, 0, 1, 1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h304,      32'h300,      32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h304,      32'h300,      32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          1, 32'h304,      32'h300,      32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          0, 32'h308,      32'h300,      32'h13,       0);
    v(1, 0, 0, 1, 0, 32'h0,        1, 1, 32'hA000_0304,  0, 32'h308,      32'h300,      32'h13,       0);
    // address wrap
    v(1, 0, 1, 1, 1, 32'hFFFF_FFFF, 1, 0, 32'h0,         0, 32'h308,      32'h304,      32'hA000_0304, 1);
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'h304,     32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 1, 32'h1234_5678,  1, 32'h0,        32'h304,      32'h13,       0);
    // reset mid-WAIT
    v(1, 1, 1, 1, 0, 32'h0,        1, 0, 32'h0,          0, 32'h4,        32'hFFFF_FFFC, 32'h1234_5678, 1);
    v(1, 0, 0, 1, 0, 32'h0,        1, 0, 32'h0,          0, 32'h0,        32'h0,        32'h13,       0);
    v(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0,          1, 32'h0,        32'h0,        32'h13,       0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset          = vecs[i].rst;
      PCWrite        = vecs[i].pw;
      IF_ID_Write    = vecs[i].iw;
      Flush_ID       = vecs[i].fl;
      BranchTarget   = vecs[i].bt;
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].rd;
      #2;
      if (vecs[i].chk)
        check_outs(i, vecs[i].qv, vecs[i].qa, vecs[i].pc, vecs[i].in, vecs[i].va);
    end

    // PCWrite=0 with IF_ID_Write=1: response for PC 0 lands directly, then bubbles
    @(negedge clk);
    PCWrite = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0000;
    #2 check("drain_no_issue", 100, {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #2;
    check("drain_pc",    101, PC_ID, 32'h0);
    check("drain_instr", 101, Instr_ID, 32'hDEAD_0000);
    check("drain_valid", 101, {31'd0, Valid_ID}, 32'd1);
    @(negedge clk);
    #2;
    check("bubble_instr", 102, Instr_ID, 32'h13);
    check("bubble_valid", 102, {31'd0, Valid_ID}, 32'd0);
    check("bubble_addr",  102, imem_req_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
